ov7670_capture_param: RTL and testbench

Parametrised OV7670 pixel-capture block. It assembles RGB565 byte pairs from the camera bus, reduces them to a configurable frame-buffer word width, and writes them to a linear frame-buffer address. It adds optional 2x2 decimation, per-line/per-frame length checking and frame-done/frame-ok status. It sits between the camera pins and the dual-port frame buffer read by the VGA controller.

---
 rtl/ov7670_pkg.sv | 29 ++
 rtl/ov7670_capture_param_pixel_pack.sv | 71 +++++++
 rtl/ov7670_capture_param.sv | 161 ++++++++++++++++
 tb/tb_ov7670_capture_param.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types, legal frame-buffer word widths and the RGB565 reduction helper
// for the OV7670 capture path.
package ov7670_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSync,
        StActive,
        StDone
    } cap_state_e;

    localparam int unsigned OUT_W_RGB333 = 9;
    localparam int unsigned OUT_W_RGB444 = 12;
    localparam int unsigned OUT_W_RGB565 = 16;

    // Result is right-aligned; callers keep the low out_w bits.
    function automatic logic [15:0] rgb565_reduce(input logic [15:0] p,
                                                  input int unsigned out_w);
        logic [15:0] r;
        r = p;
        if (out_w == OUT_W_RGB333) begin
            r = {7'd0, p[15:13], p[10:8], p[4:2]};
        end else if (out_w == OUT_W_RGB444) begin
            r = {4'd0, p[15:12], p[10:7], p[4:1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/ov7670_capture_param_pixel_pack.sv
// Camera input register stage, byte pairing and RGB565 reduction.
// Emits a one-cycle pixel_valid_o with the reduced pixel on the second byte.
module ov7670_pixel_pack
    import ov7670_pkg::*;
#(
    parameter int unsigned OUT_W = OUT_W_RGB333
) (
    input  logic             pclk_i,
    input  logic             rst_n,
    input  logic             vsync_i,
    input  logic             href_i,
    input  logic [7:0]       d_i,
    output logic             vsync_rise_o,
    output logic             vsync_fall_o,
    output logic             href_o,
    output logic             href_fall_o,
    output logic             phase_o,
    output logic             pixel_valid_o,
    output logic [OUT_W-1:0] pixel_o
);

    logic       vsync_q, vsync_q2;
    logic       href_q, href_q2;
    logic [7:0] d_q;
    logic [7:0] hi_q, hi_d;
    logic       phase_q, phase_d;
    logic       byte_ok;

    // vsync takes priority over href: bytes seen during blanking are ignored.
    assign byte_ok = href_q & ~vsync_q;

    always_comb begin
        phase_d = 1'b0;
        hi_d    = hi_q;
        if (byte_ok) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = d_q;
            end
        end
    end

    always_ff @(posedge pclk_i or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
            href_q   <= 1'b0;
            href_q2  <= 1'b0;
            d_q      <= 8'd0;
            hi_q     <= 8'd0;
            phase_q  <= 1'b0;
        end else begin
            vsync_q  <= vsync_i;
            vsync_q2 <= vsync_q;
            href_q   <= href_i;
            href_q2  <= href_q;
            d_q      <= d_i;
            hi_q     <= hi_d;
            phase_q  <= phase_d;
        end
    end

    assign vsync_rise_o  = vsync_q & ~vsync_q2;
    assign vsync_fall_o  = ~vsync_q & vsync_q2;
    assign href_o        = href_q;
    assign href_fall_o   = ~href_q & href_q2;
    assign phase_o       = phase_q;
    assign pixel_valid_o = byte_ok & phase_q;
    assign pixel_o       = OUT_W'(rgb565_reduce({hi_q, d_q}, OUT_W));

endmodule

// File: rtl/ov7670_capture_param.sv
// OV7670 capture top: frame FSM, pixel/line counters, linear write address,
// optional 2x2 decimation and line/frame integrity status.
module ov7670_capture_param
    import ov7670_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned OUT_W    = OUT_W_RGB333,
    parameter int unsigned DECIM    = 0,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic              pclk_i,
    input  logic              rst_n,
    input  logic              enable_i,
    input  logic              vsync_i,
    input  logic              href_i,
    input  logic [7:0]        d_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [OUT_W-1:0]  dout_o,
    output logic              we_o,
    output logic              frame_done_o,
    output logic              frame_ok_o,
    output logic              line_err_o
);

    localparam int unsigned XW   = $clog2(H_ACTIVE + 2);
    localparam int unsigned YW   = $clog2(V_ACTIVE + 2);
    localparam int unsigned NPIX = (H_ACTIVE >> DECIM) * (V_ACTIVE >> DECIM);
    localparam logic [XW-1:0]     HA   = XW'(H_ACTIVE);
    localparam logic [XW-1:0]     XSAT = XW'(H_ACTIVE + 1);
    localparam logic [YW-1:0]     VA   = YW'(V_ACTIVE);
    localparam logic [YW-1:0]     YSAT = YW'(V_ACTIVE + 1);
    localparam logic [ADDR_W-1:0] AMAX = ADDR_W'(NPIX - 1);

    logic             vsync_rise, vsync_fall, href_q, href_fall, phase;
    logic             pixel_valid;
    logic [OUT_W-1:0] pixel;

    ov7670_pixel_pack #(
        .OUT_W(OUT_W)
    ) u_pack (
        .pclk_i       (pclk_i),
        .rst_n        (rst_n),
        .vsync_i      (vsync_i),
        .href_i       (href_i),
        .d_i          (d_i),
        .vsync_rise_o (vsync_rise),
        .vsync_fall_o (vsync_fall),
        .href_o       (href_q),
        .href_fall_o  (href_fall),
        .phase_o      (phase),
        .pixel_valid_o(pixel_valid),
        .pixel_o      (pixel)
    );

    cap_state_e        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OUT_W-1:0]  dout_q, dout_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic              line_err_q, line_err_d;
    logic              keep;

    assign keep = (DECIM == 0) || (!x_q[0] && !y_q[0]);

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        line_err_d = line_err_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        ok_d       = 1'b0;
        addr_d     = addr_q;
        if (we_q && addr_q != AMAX) begin
            addr_d = addr_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    state_d = StSync;
                end
            end
            StSync: begin
                if (vsync_fall) begin
                    state_d    = StActive;
                    x_d        = '0;
                    y_d        = '0;
                    line_err_d = 1'b0;
                    addr_d     = '0;
                end
            end
            StActive: begin
                if (pixel_valid) begin
                    we_d = (x_q < HA) && (y_q < VA) && keep;
                    if (x_q != XSAT) begin
                        x_d = x_q + 1'b1;
                    end
                end
                if (href_fall) begin
                    x_d = '0;
                    if (y_q != YSAT) begin
                        y_d = y_q + 1'b1;
                    end
                    if (phase || x_q != HA) begin
                        line_err_d = 1'b1;
                    end
                end
                if (vsync_rise) begin
                    // A line still in progress is abandoned and flagged.
                    if (href_q) begin
                        line_err_d = 1'b1;
                    end
                    state_d = StDone;
                    done_d  = 1'b1;
                    ok_d    = !line_err_d && (y_d == VA);
                end
            end
            StDone: begin
                state_d = enable_i ? StSync : StIdle;
            end
            default: state_d = StIdle;
        endcase
        dout_d = we_d ? pixel : dout_q;
    end

    always_ff @(posedge pclk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            dout_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            line_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            line_err_q <= line_err_d;
        end
    end

    assign addr_o       = addr_q;
    assign dout_o       = dout_q;
    assign we_o         = we_q;
    assign frame_done_o = done_q;
    assign frame_ok_o   = ok_q;
    assign line_err_o   = line_err_q;

endmodule

// File: tb/tb_ov7670_capture_param.sv
// Scoreboard bench: three capture instances (RGB333, RGB565, RGB444 decimated)
// share one camera bus; each write is checked for address, data and latency.
module tb_ov7670_capture_param;

    logic       pclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       vsync = 1'b1;
    logic       href = 1'b0;
    logic [7:0] d = 8'd0;

    logic [2:0]  addr_a, addr_b;
    logic [1:0]  addr_c;
    logic [8:0]  dout_a;
    logic [15:0] dout_b;
    logic [11:0] dout_c;
    logic we_a, we_b, we_c, dn_a, dn_b, dn_c, ok_a, ok_b, ok_c, le_a, le_b, le_c;

    always #5 pclk = ~pclk;

    ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .OUT_W(9), .DECIM(0), .ADDR_W(3)) u_a (
        .pclk_i(pclk), .rst_n(rst_n), .enable_i(enable), .vsync_i(vsync), .href_i(href),
        .d_i(d), .addr_o(addr_a), .dout_o(dout_a), .we_o(we_a), .frame_done_o(dn_a),
        .frame_ok_o(ok_a), .line_err_o(le_a));

    ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(2), .OUT_W(16), .DECIM(0), .ADDR_W(3)) u_b (
        .pclk_i(pclk), .rst_n(rst_n), .enable_i(enable), .vsync_i(vsync), .href_i(href),
        .d_i(d), .addr_o(addr_b), .dout_o(dout_b), .we_o(we_b), .frame_done_o(dn_b),
        .frame_ok_o(ok_b), .line_err_o(le_b));

    ov7670_capture_param #(.H_ACTIVE(4), .V_ACTIVE(4), .OUT_W(12), .DECIM(1), .ADDR_W(2)) u_c (
        .pclk_i(pclk), .rst_n(rst_n), .enable_i(enable), .vsync_i(vsync), .href_i(href),
        .d_i(d), .addr_o(addr_c), .dout_o(dout_c), .we_o(we_c), .frame_done_o(dn_c),
        .frame_ok_o(ok_c), .line_err_o(le_c));

    typedef struct {
        logic [18:0] a;
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ha[3] = '{4, 4, 4};
    int va[3] = '{2, 2, 4};
    int ow[3] = '{9, 16, 12};
    int dc[3] = '{0, 0, 1};
    int maddr[3];
    bit mcap[3];
    int done_cnt[3];
    logic ok_seen[3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] red(input logic [15:0] p, input int w);
        if (w == 9) return {7'd0, p[15], p[14], p[13], p[10], p[9], p[8], p[4], p[3], p[2]};
        if (w == 12) return {4'd0, p[15:12], p[10:7], p[4:1]};
        return p;
    endfunction

    function automatic int sb_size(input int i);
        if (i == 0) return q0.size();
        if (i == 1) return q1.size();
        return q2.size();
    endfunction

    task automatic sb_push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else if (i == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic sb_pop(input int i, output exp_t e);
        if (i == 0) e = q0.pop_front();
        else if (i == 1) e = q1.pop_front();
        else e = q2.pop_front();
    endtask

    task automatic sample();
        logic [2:0]  we_v, dn_v, ok_v;
        logic [18:0] ad_v[3];
        logic [15:0] do_v[3];
        exp_t        e;
        we_v = {we_c, we_b, we_a};
        dn_v = {dn_c, dn_b, dn_a};
        ok_v = {ok_c, ok_b, ok_a};
        ad_v[0] = 19'(addr_a);
        ad_v[1] = 19'(addr_b);
        ad_v[2] = 19'(addr_c);
        do_v[0] = 16'(dout_a);
        do_v[1] = dout_b;
        do_v[2] = 16'(dout_c);
        for (int i = 0; i < 3; i++) begin
            if (dn_v[i]) begin
                done_cnt[i]++;
                ok_seen[i] = ok_v[i];
            end
            if (we_v[i]) begin
                if (sb_size(i) == 0) begin
                    chk($sformatf("unexpected_we[%0d]", i), 32'(we_v[i]), 32'd0);
                end else begin
                    sb_pop(i, e);
                    chk($sformatf("addr[%0d]", i), 32'(ad_v[i]), 32'(e.a));
                    chk($sformatf("dout[%0d]", i), 32'(do_v[i]), 32'(e.d));
                    chk($sformatf("we_cycle[%0d]", i), 32'(cyc), 32'(e.c));
                end
            end
        end
    endtask

    task automatic step(input logic vs, input logic hr, input logic [7:0] dd);
        vsync = vs;
        href  = hr;
        d     = dd;
        @(posedge pclk);
        @(negedge pclk);
        cyc++;
        sample();
    endtask

    // Write lands two sampling points after the second byte is driven.
    task automatic push_pixel(input int x, input int y, input logic [15:0] p);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (mcap[i] && x < ha[i] && y < va[i] &&
                (dc[i] == 0 || (x % 2 == 0 && y % 2 == 0))) begin
                e.a = 19'(maddr[i]);
                e.d = red(p, ow[i]);
                e.c = cyc + 2;
                sb_push(i, e);
                maddr[i]++;
            end
        end
    endtask

    task automatic send_line(input int nbytes, input int y, input logic [7:0] hi0,
                             input logic [7:0] lo0, input int inc);
        logic [7:0] hi, lo;
        for (int b = 0; b < nbytes; b++) begin
            hi = 8'(int'(hi0) + inc * (b / 2) * 17);
            lo = 8'(int'(lo0) + inc * ((b / 2) * 3 + y));
            if (b % 2 == 0) begin
                step(1'b0, 1'b1, hi);
            end else begin
                push_pixel(b / 2, y, {hi, lo});
                step(1'b0, 1'b1, lo);
            end
        end
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic vs_high();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'd0);
    endtask

    task automatic vs_fall();
        for (int i = 0; i < 3; i++) maddr[i] = 0;
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
    endtask

    task automatic end_frame(input string tag, input logic [2:0] exp_done,
                             input logic [2:0] exp_ok);
        for (int i = 0; i < 3; i++) done_cnt[i] = 0;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_done_cnt[%0d]", tag, i), 32'(done_cnt[i]), 32'(exp_done[i]));
            if (exp_done[i]) begin
                chk($sformatf("%s_frame_ok[%0d]", tag, i), 32'(ok_seen[i]), 32'(exp_ok[i]));
            end
            chk($sformatf("%s_missing_writes[%0d]", tag, i), 32'(sb_size(i)), 32'd0);
        end
    endtask

    initial begin
        @(negedge pclk);
        #1;
        chk("rst_addr", 32'({addr_a, addr_b, addr_c}), 32'd0);
        chk("rst_dout", 32'({dout_a, dout_b}), 32'd0);
        chk("rst_flags", 32'({we_a, dn_a, ok_a, le_a, we_b, dn_b, ok_b, le_b}), 32'd0);
        @(negedge pclk);
        rst_n  = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) mcap[i] = 1'b1;

        // Clean frame of 0xF8,0x1F pixels.
        vs_high();
        vs_fall();
        send_line(8, 0, 8'hF8, 8'h1F, 0);
        send_line(8, 1, 8'hF8, 8'h1F, 0);
        end_frame("t1", 3'b111, 3'b011);

        // Varying pixels starting with 0x12,0x34; latency checked on every write.
        vs_high();
        vs_fall();
        send_line(8, 0, 8'h12, 8'h34, 1);
        send_line(8, 1, 8'hA0, 8'h0F, 1);
        end_frame("t2", 3'b111, 3'b011);

        // Four lines: only the decimating instance sees a complete frame.
        vs_high();
        vs_fall();
        send_line(8, 0, 8'h21, 8'h43, 1);
        send_line(8, 1, 8'h65, 8'h87, 1);
        send_line(8, 2, 8'hA9, 8'hCB, 1);
        send_line(8, 3, 8'hED, 8'h0F, 1);
        end_frame("t3", 3'b111, 3'b100);

        // Odd byte count on line 1.
        vs_high();
        vs_fall();
        send_line(8, 0, 8'h5A, 8'hC3, 1);
        chk("t4_line_err_clean", 32'(le_a), 32'd0);
        send_line(7, 1, 8'h3C, 8'h96, 1);
        chk("t4_line_err_odd_a", 32'(le_a), 32'd1);
        chk("t4_line_err_odd_c", 32'(le_c), 32'd1);
        end_frame("t4", 3'b111, 3'b000);
        vs_high();
        chk("t4_line_err_sticky", 32'(le_a), 32'd1);
        vs_fall();
        chk("t4_line_err_cleared", 32'({le_a, le_b, le_c}), 32'd0);

        // Over-long line, then a surplus third line.
        send_line(12, 0, 8'h11, 8'h22, 1);
        chk("t5_line_err_long", 32'(le_a), 32'd1);
        send_line(8, 1, 8'h33, 8'h44, 1);
        send_line(8, 2, 8'h55, 8'h66, 1);
        end_frame("t5", 3'b111, 3'b000);

        // Enable dropped mid-frame: frame completes, then nothing more.
        vs_high();
        vs_fall();
        send_line(8, 0, 8'h77, 8'h88, 1);
        enable = 1'b0;
        send_line(8, 1, 8'h99, 8'hAA, 1);
        end_frame("t6a", 3'b111, 3'b011);
        for (int i = 0; i < 3; i++) mcap[i] = 1'b0;
        vs_high();
        vs_fall();
        send_line(8, 0, 8'hBB, 8'hCC, 1);
        send_line(8, 1, 8'hDD, 8'hEE, 1);
        end_frame("t6a_idle", 3'b000, 3'b000);

        // Reset pulsed part-way into line 1.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) mcap[i] = 1'b1;
        vs_high();
        vs_fall();
        send_line(8, 0, 8'hE1, 8'h1E, 1);
        step(1'b0, 1'b1, 8'hD2);
        push_pixel(0, 1, 16'hD22D);
        step(1'b0, 1'b1, 8'h2D);
        step(1'b0, 1'b1, 8'hC3);
        rst_n = 1'b0;
        #1;
        chk("t6b_rst_addr", 32'({addr_a, addr_b, addr_c}), 32'd0);
        chk("t6b_rst_dout", 32'({dout_a, dout_b, dout_c}), 32'd0);
        chk("t6b_rst_flags", 32'({we_a, dn_a, ok_a, le_a, we_b, dn_b, ok_b, le_b}), 32'd0);
        for (int i = 0; i < 3; i++) mcap[i] = 1'b0;
        step(1'b0, 1'b1, 8'h3C);
        step(1'b0, 1'b1, 8'h4B);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        end_frame("t6b", 3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
